// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the word-indexed PC, reads the instruction memory and registers a fetch packet for decode.
// Optional bounds checking of the PC is enabled by defining IFU_BOUNDS_CHECK_EN.
module instr_fetch_unit #(
  parameter int RESET_PC   = 0,
  parameter int IMEM_DEPTH = 128,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rsta_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic [CNT_W-1:0] fetch_count,
  output logic             fault
);

  localparam logic [31:0] ADDR_MASK = 32'(IMEM_DEPTH - 1);
  localparam logic [31:0] PC_RESET  = 32'(RESET_PC);

  logic [31:0]      pc_r;
  logic [31:0]      pc_nxt_s;
  logic             if_valid_r;
  logic             if_valid_nxt_s;
  logic [31:0]      if_instr_r;
  logic [31:0]      if_instr_nxt_s;
  logic [31:0]      if_pc_r;
  logic [31:0]      if_pc_nxt_s;
  logic [CNT_W-1:0] fetch_count_r;
  logic [CNT_W-1:0] fetch_count_nxt_s;
  logic             fault_r;
  logic             fault_nxt_s;

  logic             redir_take_s;
  logic             fire_s;
  logic             drain_s;
  logic             redir_oob_s;
  logic             incr_oob_s;

  // Out-of-range detection for redirect targets and sequential increments
`ifdef IFU_BOUNDS_CHECK_EN
  always_comb begin
    redir_oob_s = (redirect_target > ADDR_MASK);
    incr_oob_s  = (pc_r >= ADDR_MASK);
  end
`else
  always_comb begin
    redir_oob_s = 1'b0;
    incr_oob_s  = 1'b0;
  end
`endif

  // Handshake qualifiers; a latched fault swallows redirects and blocks fetching
  always_comb begin
    redir_take_s = redirect_valid & ~fault_r;
    fire_s       = ~redirect_valid & ~stall & ~fault_r & (~if_valid_r | if_ready);
    drain_s      = if_valid_r & if_ready;
  end

  // Next-state selection: redirect, then fire, then drain, else hold
  always_comb begin
    pc_nxt_s          = pc_r;
    if_valid_nxt_s    = if_valid_r;
    if_instr_nxt_s    = if_instr_r;
    if_pc_nxt_s       = if_pc_r;
    fetch_count_nxt_s = fetch_count_r;
    fault_nxt_s       = fault_r;
    if (redir_take_s) begin
      if_valid_nxt_s = 1'b0;
      if (redir_oob_s) begin
        fault_nxt_s = 1'b1;
        pc_nxt_s    = redirect_target;
      end else begin
        pc_nxt_s    = redirect_target & ADDR_MASK;
      end
    end else if (fire_s) begin
      if_instr_nxt_s    = imem_data;
      if_pc_nxt_s       = pc_r;
      if_valid_nxt_s    = 1'b1;
      fetch_count_nxt_s = fetch_count_r + CNT_W'(1'b1);
      // The last in-range address stays in the PC when a fault is raised
      if (incr_oob_s) begin
        fault_nxt_s = 1'b1;
        pc_nxt_s    = pc_r;
      end else begin
        pc_nxt_s    = (pc_r + 32'd1) & ADDR_MASK;
      end
    end else if (drain_s) begin
      if_valid_nxt_s = 1'b0;
    end else begin
      if_valid_nxt_s = if_valid_r;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rsta_n) begin
    if (!rsta_n) begin
      pc_r          <= PC_RESET;
      if_valid_r    <= 1'b0;
      if_instr_r    <= 32'd0;
      if_pc_r       <= 32'd0;
      fetch_count_r <= '0;
      fault_r       <= 1'b0;
    end else begin
      pc_r          <= pc_nxt_s;
      if_valid_r    <= if_valid_nxt_s;
      if_instr_r    <= if_instr_nxt_s;
      if_pc_r       <= if_pc_nxt_s;
      fetch_count_r <= fetch_count_nxt_s;
      fault_r       <= fault_nxt_s;
    end
  end

  assign imem_addr   = pc_r;
  assign if_valid    = if_valid_r;
  assign if_instr    = if_instr_r;
  assign if_pc       = if_pc_r;
  assign fetch_count = fetch_count_r;
  assign fault       = fault_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for instr_fetch_unit (default build, bounds checking disabled).
module tb_instr_fetch_unit;

  logic        clk;
  logic        rsta_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [15:0] fetch_count;
  logic        fault;

  int n_vec;
  int n_err;

  instr_fetch_unit #(.RESET_PC(0), .IMEM_DEPTH(128), .CNT_W(16)) dut (
    .clk             (clk),
    .rsta_n          (rsta_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .fetch_count     (fetch_count),
    .fault           (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000_0000 + (a & 32'd127);
  endfunction

  assign imem_data = word_at(imem_addr);

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic [15:0] ecnt;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] tgt, input logic rdy,
                              input logic ev, input logic [31:0] epc, input logic [31:0] eaddr,
                              input logic [15:0] ecnt);
    vec_t v;
    v.stall = s; v.rv = rv; v.tgt = tgt; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                         input logic [31:0] einstr, input logic [31:0] eaddr,
                         input logic [15:0] ecnt, input logic efault);
    n_vec++;
    chk({tag, ".if_valid"},    {31'd0, if_valid}, {31'd0, ev});
    chk({tag, ".if_pc"},       if_pc, epc);
    chk({tag, ".if_instr"},    if_instr, einstr);
    chk({tag, ".imem_addr"},   imem_addr, eaddr);
    chk({tag, ".fetch_count"}, {16'd0, fetch_count}, {16'd0, ecnt});
    chk({tag, ".fault"},       {31'd0, fault}, {31'd0, efault});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[22];

  initial begin
    n_vec = 0;
    n_err = 0;

    // stall rv tgt rdy | valid if_pc imem_addr count
    tbl[0]  = mk(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd0,   32'd1,   16'd1);
    tbl[1]  = mk(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd1,   32'd2,   16'd2);
    tbl[2]  = mk(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd2,   32'd3,   16'd3);
    tbl[3]  = mk(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd3,   32'd4,   16'd4);
    tbl[4]  = mk(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd4,   32'd5,   16'd5);
    tbl[5]  = mk(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd5,   32'd6,   16'd6);
    tbl[6]  = mk(1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 32'd5,   32'd6,   16'd6);
    tbl[7]  = mk(1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 32'd5,   32'd6,   16'd6);
    tbl[8]  = mk(1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 32'd5,   32'd6,   16'd6);
    tbl[9]  = mk(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd6,   32'd7,   16'd7);
    tbl[10] = mk(1'b1, 1'b0, 32'd0,   1'b1, 1'b0, 32'd6,   32'd7,   16'd7);
    tbl[11] = mk(1'b1, 1'b0, 32'd0,   1'b1, 1'b0, 32'd6,   32'd7,   16'd7);
    tbl[12] = mk(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd7,   32'd8,   16'd8);
    tbl[13] = mk(1'b0, 1'b1, 32'd20,  1'b0, 1'b0, 32'd7,   32'd20,  16'd8);
    tbl[14] = mk(1'b0, 1'b0, 32'd0,   1'b0, 1'b1, 32'd20,  32'd21,  16'd9);
    tbl[15] = mk(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd21,  32'd22,  16'd10);
    tbl[16] = mk(1'b0, 1'b1, 32'd126, 1'b1, 1'b0, 32'd21,  32'd126, 16'd10);
    tbl[17] = mk(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd126, 32'd127, 16'd11);
    tbl[18] = mk(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd127, 32'd0,   16'd12);
    tbl[19] = mk(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd0,   32'd1,   16'd13);
    tbl[20] = mk(1'b1, 1'b1, 32'd200, 1'b1, 1'b0, 32'd0,   32'd72,  16'd13);
    tbl[21] = mk(1'b0, 1'b0, 32'd0,   1'b1, 1'b1, 32'd72,  32'd73,  16'd14);

    rsta_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'd0;
    if_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 32'd0, 32'd0, 32'd0, 16'd0, 1'b0);
    @(negedge clk);
    rsta_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      stall = tbl[i].stall;
      redirect_valid = tbl[i].rv;
      redirect_target = tbl[i].tgt;
      if_ready = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, word_at(tbl[i].epc),
              tbl[i].eaddr, tbl[i].ecnt, 1'b0);
    end

    // Mid-stream reset with a valid packet at pc 9
    stall = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'd9;
    if_ready = 1'b0;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    redirect_target = 32'd0;
    @(posedge clk);
    #1;
    chk_all("pre_rst", 1'b1, 32'd9, word_at(32'd9), 32'd10, 16'd15, 1'b0);
    #2;
    rsta_n = 1'b0;
    #1;
    chk_all("mid_rst", 1'b0, 32'd0, 32'd0, 32'd0, 16'd0, 1'b0);
    @(negedge clk);
    rsta_n = 1'b1;
    if_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst", 1'b1, 32'd0, word_at(32'd0), 32'd1, 16'd1, 1'b0);

    // Redirect and stall together with ready low: flush then a held packet
    if_ready = 1'b0;
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'd50;
    @(posedge clk);
    #1;
    chk_all("redir_stall", 1'b0, 32'd0, word_at(32'd0), 32'd50, 16'd1, 1'b0);
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("stall_hold", 1'b0, 32'd0, word_at(32'd0), 32'd50, 16'd1, 1'b0);
    stall = 1'b0;
    @(posedge clk);
    #1;
    chk_all("after_stall", 1'b1, 32'd50, word_at(32'd50), 32'd51, 16'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction memory in the single-issue 32-bit core.
- Owns the program counter (word-indexed: one address step per 32-bit instruction) and drives the instruction memory's word address.
- Captures the returned word into a registered fetch packet and hands it to decode over a valid/ready handshake.
- Accepts redirects from execute and stalls from hazard logic; includes a fetch counter for debug.

Parameters:
- RESET_PC, 0, word address loaded into the PC at reset.
- IMEM_DEPTH, 128, number of instruction words; must be a power of two.
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  in  1  core clock, rising-edge.
- rsta_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard stall; blocks new fetches.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  32  absolute word address of the new PC.
- imem_addr  out  32  word address to the instruction memory (= pc, combinational).
- imem_data  in  32  instruction word; combinational read of imem_addr, same cycle.
- if_valid  out  1  fetch packet valid.
- if_ready  in  1  decode accepts the packet.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  word address of if_instr.
- fetch_count  out  CNT_W  number of accepted fetches; wraps.
- fault  out  1  bounds fault (see Optional Feature).

Behaviour:
- Reset (async assert, sync-safe deassert): pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, fetch_count=0, fault=0.
- Define fire = !redirect_valid & !stall & !fault & (!if_valid | if_ready).
- Redirect has top priority, regardless of stall or if_ready:
  - pc <= redirect_target & (IMEM_DEPTH-1).
  - if_valid <= 0; the packet is flushed even if if_ready is high.
  - No fetch that cycle.
  - The first fetch from the new target is valid no earlier than 2 cycles after redirect_valid is sampled.
- On fire:
  - if_instr <= imem_data; if_pc <= pc; if_valid <= 1; fetch_count <= fetch_count+1.
  - pc <= (pc+1) & (IMEM_DEPTH-1); the PC wraps from IMEM_DEPTH-1 to 0.
- Otherwise, if if_valid & if_ready: if_valid <= 0 and the packet fields hold their values.
- Otherwise all state holds. A valid packet is stable (if_instr/if_pc unchanged) until accepted or flushed.
- Throughput: with stall=0 and if_ready=1 continuously, one packet per cycle. Latency is 1 cycle from imem_addr to if_valid.
- stall=1 with a valid packet and if_ready=1: the packet is consumed, if_valid drops, and pc holds.
- if_ready=0 with if_valid=1: the pipeline is blocked; pc holds and imem_addr holds.
- Reset asserted mid-operation: all state returns to reset values immediately; the packet is discarded.
- fetch_count counts fire events only; redirects and flushes do not increment it.

Optional Feature:
- Macro IFU_BOUNDS_CHECK_EN.
- Defined:
  - fault sets, and stays set until reset, in either of these cases:
    - redirect_target >= IMEM_DEPTH when a redirect is taken;
    - a fire would advance pc past IMEM_DEPTH-1.
  - On fault, the pc freezes at the offending value (target or last address). The current if_valid packet may still drain, and no further fire occurs.
  - A redirect arriving while fault=1 is ignored.
- Not defined: fault is tied to 0; targets and increments are masked and wrap as described above.

Test Plan:
- Reset, then stall=0, if_ready=1, with memory words w[k]=0x1000_0000+k -> imem_addr steps 0,1,2,...; if_pc/if_instr = (0,0x10000000), (1,0x10000001), ... on consecutive cycles; fetch_count=3 after 3 packets.
- if_ready=0 for 3 cycles with a packet at pc 5 -> if_pc=5 and if_instr stable, imem_addr=6 held, fetch_count unchanged; ready=1 -> the pc 6 packet arrives the next cycle.
- Redirect to 20 while if_valid=1 and if_ready=0 -> next cycle if_valid=0 and imem_addr=20; the following cycle if_pc=20. The flushed packet is never accepted and the count is not bumped.
- Sequential fetch from 126 -> packets 126, 127, 0 (no macro); with IFU_BOUNDS_CHECK_EN -> packets 126, 127, then fault=1, pc frozen at 127, if_valid=0 after drain.
- Redirect_target 200 -> without macro the PC becomes 72 (200 & 127); with macro fault=1 and no further packets.
- Assert rsta_n=0 mid-stream at pc 9 with if_valid=1 -> immediately if_valid=0 and fetch_count=0; after release, fetch restarts at RESET_PC.
